// File: rtl/multibyte_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multibyte_add_ctrl (with helper parallel_add)
// Purpose  : NBYTES-wide add/subtract built from one shared 8-bit
//            ripple-carry adder. Works one byte per clock, LSB first.
//            Provides a start/busy/done handshake.
// Options  : ADDCTL_OVF_EN - when defined, ovf reports signed overflow.
//            When undefined, ovf is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================

// 8-bit ripple-carry adder shared by the sequencer
module parallel_add (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cyout
);
  logic [8:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
      assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cyout = w_c[8];
endmodule

module multibyte_add_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf
);
  localparam int c_W     = 8 * NBYTES;
  localparam int c_IDX_W = $clog2(NBYTES);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NBYTES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_done_nxt;
  logic                 w_busy;
  logic                 w_last;

  logic [c_W-1:0]       r_a;
  logic [c_W-1:0]       r_b;
  logic                 r_sub;
  logic                 r_c;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_W-1:0]       r_result;
  logic                 r_cout;
  logic                 r_done;

  logic [c_IDX_W+2:0]   w_base;
  logic [7:0]           w_a;
  logic [7:0]           w_b;
  logic [7:0]           w_s;
  logic                 w_cy;

  // Byte lane selection; b is inverted for subtraction (two's complement
  // completed by c_r starting at 1).
  assign w_base = {r_idx, 3'b000};
  assign w_a    = r_a[w_base +: 8];
  assign w_b    = r_b[w_base +: 8] ^ {8{r_sub}};
  assign w_last = (r_idx == c_LAST);

  parallel_add u_add (
    .a     (w_a),
    .b     (w_b),
    .cin   (r_c),
    .s     (w_s),
    .cyout (w_cy)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, carry chain, byte-wise result write and done pulse.
  // idx returns to 0 after the last byte so the lane mux never
  // points past the operand in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_c      <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_accept) begin
        r_a    <= op_a;
        r_b    <= op_b;
        r_sub  <= sub;
        r_c    <= sub;
        r_idx  <= '0;
        r_cout <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_result[w_base +: 8] <= w_s;
        r_c                   <= w_cy;
        if (w_last) begin
          r_idx  <= '0;
          r_cout <= w_cy;
        end else begin
          r_idx  <= r_idx + 1'b1;
        end
      end
    end
  end

`ifdef ADDCTL_OVF_EN
  logic r_ovf;
  logic w_cmsb;

  // Carry into the MSB, recovered from the sum bit
  assign w_cmsb = w_a[7] ^ w_b[7] ^ w_s[7];

  // Signed overflow captured on the final byte pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_ovf <= 1'b0;
    else if (w_accept)                     r_ovf <= 1'b0;
    else if ((r_state == ST_RUN) && w_last) r_ovf <= w_cmsb ^ w_cy;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = w_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
endmodule
`default_nettype wire

// File: doc/multibyte_add_ctrl.md
# multibyte_add_ctrl

Sequencer that performs NBYTES-wide addition or subtraction by time-multiplexing one instance of the team's 8-bit ripple-carry adder, `parallel_add`, one byte per clock, least-significant byte first. It owns the carry chain between passes, latches operands and result, and presents a start/busy/done handshake to the requesting logic. It sits between wide-operand control logic and the shared 8-bit adder datapath. It trades latency for area compared with an NBYTES-wide combinational adder.

## Interface
- NBYTES, default 4: operand width in bytes; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; latched with start.
- op_a  input  8*NBYTES  operand A; latched with start.
- op_b  input  8*NBYTES  operand B; latched with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result, cout and ovf become valid.
- result  output  8*NBYTES  sum or difference.
- cout  output  1  final carry out. In subtract mode, 1 means no borrow.
- ovf  output  1  signed overflow (see Configuration).

## Operation
- FSM states: IDLE and RUN. Internal registers:
  - A_r, B_r: 8*NBYTES each.
  - idx: $clog2(NBYTES) bits.
  - c_r: 1 bit.
  - sub_r: 1 bit.
- Accepting a request: in IDLE with start=1, the next edge does all of the following:
  - latch op_a→A_r, op_b→B_r, sub→sub_r;
  - set idx=0 and c_r=sub;
  - clear cout and ovf, and go to RUN.
- Adder hookup (combinational):
  - a = A_r byte[idx];
  - b = B_r byte[idx] XOR {8{sub_r}};
  - cin = c_r.
- Each RUN edge:
  - write adder s into result byte[idx];
  - c_r ← cyout;
  - idx ← idx+1.
- Last byte (idx == NBYTES−1) at a RUN edge, in addition to the byte update:
  - cout ← cyout;
  - ovf ← signed-overflow term;
  - done ← 1;
  - state → IDLE.
- Result bytes not yet written keep their previous values while RUN is in progress. result is only guaranteed valid while done=1 and afterwards.
- result, cout and ovf hold their values until the next accepted start.
- start while in RUN is ignored and not queued. Operand changes during RUN have no effect.
- All arithmetic is modulo 2^(8*NBYTES). There are no exceptions and no saturation.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, state=IDLE, idx=0, c_r=0.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values. No done pulse is issued.
- Edge E0 accepts start. busy is high from E0 through EN, where EN is the NBYTES-th RUN edge.
- At EN: busy falls and done rises for exactly one cycle. Latency from the accepting edge to done is NBYTES cycles.
- A new start can be sampled at EN+1 (the cycle in which done is high). That gives back-to-back throughput of one operation per NBYTES+1 cycles.
- The adder is purely combinational. The path from A_r/B_r/c_r through the 8-bit ripple chain to result/c_r must close in one clk period.

## Configuration
- ADDCTL_OVF_EN defined:
  - ovf = carry into the MSB XOR carry out of the MSB, evaluated on the final byte pass.
  - The carry into the MSB is computed as a[7] ^ b[7] ^ s[7] (after the sub inversion of b).
- ADDCTL_OVF_EN not defined: ovf is tied to 0 and no overflow logic is synthesized.

## Test plan
- NBYTES=4, start with op_a=0x000000FF, op_b=0x00000001, sub=0 → done exactly 4 cycles after the accepting edge; result=0x00000100, cout=0.
- op_a=0xFFFFFFFF, op_b=0x00000001, sub=0 → result=0x00000000, cout=1, ovf=0.
- op_a=0x00000005, op_b=0x00000007, sub=1 → result=0xFFFFFFFE, cout=0 (borrow).
- With ADDCTL_OVF_EN: op_a=0x7FFFFFFF, op_b=0x00000001, sub=0 → result=0x80000000, ovf=1. Without the macro, ovf=0.
- Pulse start again two cycles after an accepted start, with different operands → ignored; the first operation's result is unchanged and exactly one done pulse is seen.
- Assert rst in the 3rd RUN cycle → busy, done and result go to 0 immediately. No done pulse follows. A fresh start after reset produces a correct result.
